// File: rtl/uart_rx_if.sv
// Serial receive bus for uart_rx: the line input plus the parallel word and status strobes.
// The rx_parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic             rx_data_in;
    logic [WIDTH-1:0] rx_data;
    logic             rx_done;
    logic             rx_frame_err;
    logic             rx_busy;
`ifdef UART_RX_PARITY_EN
    logic             rx_parity_err;

    modport master (output rx_data_in,
                    input  rx_data, rx_done, rx_frame_err, rx_busy, rx_parity_err);
    modport slave  (input  rx_data_in,
                    output rx_data, rx_done, rx_frame_err, rx_busy, rx_parity_err);
`else
    modport master (output rx_data_in,
                    input  rx_data, rx_done, rx_frame_err, rx_busy);
    modport slave  (input  rx_data_in,
                    output rx_data, rx_done, rx_frame_err, rx_busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, WIDTH data bits LSB first, stop_bit stop bits, mid-bit sampling.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int WIDTH    = 8,
    parameter int stop_bit = 2,
    parameter int test     = 0,
    parameter int BAUD_DIV = 5208
) (
    input  logic     rx_clk,
    input  logic     rx_rst,
    uart_rx_if.slave bus
);
    localparam int DIV = (test != 0) ? 8 : BAUD_DIV;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(stop_bit - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t           state, state_n;
    logic             s1, s2, s3;
    logic [CW-1:0]    clk_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] data_q;
    logic             done_q, ferr_q, busy_q;
    logic             fall;
    logic             cnt_clr, bit_clr, bit_inc, shift_en, done_set, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic             par_en, par_bit, perr_q;
`endif

    assign fall = s3 & ~s2;

    // Synchronizer flops idle at 1 so reset never fakes a falling edge.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= bus.rx_data_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        bit_clr  = 1'b0;
        bit_inc  = 1'b0;
        shift_en = 1'b0;
        done_set = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en   = 1'b0;
`endif
        case (state)
            IDLE: if (fall) begin
                cnt_clr = 1'b1;
                state_n = START;
            end
            START: if (clk_cnt == CNT_MID) begin
                if (s2) state_n = IDLE;
                else begin
                    cnt_clr = 1'b1;
                    bit_clr = 1'b1;
                    state_n = DATA;
                end
            end
            DATA: if (clk_cnt == CNT_MAX) begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_DATA) begin
                    bit_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end else bit_inc = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (clk_cnt == CNT_MAX) begin
                par_en  = 1'b1;
                state_n = STOP;
            end
`endif
            STOP: if (clk_cnt == CNT_MAX) begin
                if (!s2) begin
                    ferr_set = 1'b1;
                    state_n  = WAIT_IDLE;
                end else if (bit_cnt == LAST_STOP) begin
                    done_set = 1'b1;
                    state_n  = IDLE;
                end else bit_inc = 1'b1;
            end
            WAIT_IDLE: if (s2) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Free-running bit timer inside a frame; wraps so DATA/STOP sample every DIV clocks.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '0;
        end else begin
            if (cnt_clr)               clk_cnt <= '0;
            else if (state != IDLE)    clk_cnt <= (clk_cnt == CNT_MAX) ? '0 : clk_cnt + 1'b1;
            if (bit_clr)               bit_cnt <= '0;
            else if (bit_inc)          bit_cnt <= bit_cnt + 1'b1;
            if (shift_en)              sh <= {s2, sh[WIDTH-1:1]};
        end
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            data_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= done_set;
            ferr_q <= ferr_set;
            busy_q <= (state_n != IDLE);
            if (done_set) data_q <= sh;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (par_en) par_bit <= s2;
            perr_q <= done_set & (par_bit != ^sh);
        end
    end
    assign bus.rx_parity_err = perr_q;
`endif

    assign bus.rx_data      = data_q;
    assign bus.rx_done      = done_q;
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx in simulation timing (8 clocks per bit), WIDTH=8, two stop bits.
// Define UART_RX_PARITY_EN to also exercise the even-parity path.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_rx_if #(.WIDTH(8)) bus ();

    uart_rx #(.WIDTH(8), .stop_bit(2), .test(1), .BAUD_DIV(5208)) dut (
        .rx_clk (clk),
        .rx_rst (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge
    int         done_cnt = 0, ferr_cnt = 0, both_cnt = 0, wide_cnt = 0, perr_cnt = 0, perr_done = 0;
    logic       done_prev = 1'b0, ferr_prev = 1'b0, busy_seen = 1'b0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (bus.rx_done) begin
            done_cnt++;
            rxq.push_back(bus.rx_data);
        end
        if (bus.rx_frame_err) ferr_cnt++;
        if (bus.rx_done && bus.rx_frame_err) both_cnt++;
        if ((bus.rx_done && done_prev) || (bus.rx_frame_err && ferr_prev)) wide_cnt++;
        if (bus.rx_busy) busy_seen = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bus.rx_parity_err) perr_cnt++;
        if (bus.rx_parity_err && bus.rx_done) perr_done++;
`endif
        done_prev = bus.rx_done;
        ferr_prev = bus.rx_frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_time(input logic b);
        bus.rx_data_in = b;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Frame: start, data LSB first, [parity], stop1, stop2
    task automatic send_frame(input logic [7:0] d, input logic stop1_low, input logic par_flip);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^d) ^ par_flip);
`endif
        bit_time(~stop1_low);
        bit_time(1'b1);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) bit_time(1'b1);
    endtask

    int d0, f0, p0, pd0;

    initial begin
        rst = 1'b1;
        bus.rx_data_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(bus.rx_data), 32'h00);
        chk("rst_done", 32'(bus.rx_done), 32'h0);
        chk("rst_ferr", 32'(bus.rx_frame_err), 32'h0);
        chk("rst_busy", 32'(bus.rx_busy), 32'h0);
        rst = 1'b0;
        idle_bits(2);

        // Single frame with idle line around it
        send_frame(8'h0A, 1'b0, 1'b0);
        idle_bits(3);
        chk("f0A_done_cnt", 32'(done_cnt), 32'd1);
        chk("f0A_data", 32'(bus.rx_data), 32'h0A);
        chk("f0A_no_ferr", 32'(ferr_cnt), 32'd0);

        // Back-to-back frames
        rxq.delete();
        d0 = done_cnt;
        send_frame(8'h24, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        idle_bits(3);
        chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd3);
        chk("b2b_w0", (rxq.size() > 0) ? 32'(rxq[0]) : 32'hFFFF, 32'h24);
        chk("b2b_w1", (rxq.size() > 1) ? 32'(rxq[1]) : 32'hFFFF, 32'h33);
        chk("b2b_w2", (rxq.size() > 2) ? 32'(rxq[2]) : 32'hFFFF, 32'h14);

        // Short low glitch on the idle line
        d0 = done_cnt;
        busy_seen = 1'b0;
        bus.rx_data_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.rx_data_in = 1'b1;
        idle_bits(3);
        chk("glitch_busy_rose", 32'(busy_seen), 32'h1);
        chk("glitch_busy_fell", 32'(bus.rx_busy), 32'h0);
        chk("glitch_no_done", 32'(done_cnt - d0), 32'd0);
        chk("glitch_data_kept", 32'(bus.rx_data), 32'h14);

        // Framing error, then recovery
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_bits(3);
        chk("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
        chk("ferr_no_done", 32'(done_cnt - d0), 32'd0);
        chk("ferr_data_kept", 32'(bus.rx_data), 32'h14);
        send_frame(8'h5A, 1'b0, 1'b0);
        idle_bits(3);
        chk("after_ferr_done", 32'(done_cnt - d0), 32'd1);
        chk("after_ferr_data", 32'(bus.rx_data), 32'h5A);

        // Reset mid-DATA aborts the frame
        d0 = done_cnt;
        f0 = ferr_cnt;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.rx_busy), 32'h0);
        chk("arst_data", 32'(bus.rx_data), 32'h00);
        chk("arst_done", 32'(bus.rx_done), 32'h0);
        chk("arst_ferr", 32'(bus.rx_frame_err), 32'h0);
        bus.rx_data_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bits(3);
        chk("arst_no_pulses", 32'((done_cnt - d0) + (ferr_cnt - f0)), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0);
        idle_bits(3);
        chk("arst_next_done", 32'(done_cnt - d0), 32'd1);
        chk("arst_next_data", 32'(bus.rx_data), 32'h3C);

`ifdef UART_RX_PARITY_EN
        // 8'h07 has odd weight, so a correct parity bit is 1
        d0 = done_cnt; p0 = perr_cnt; pd0 = perr_done;
        send_frame(8'h07, 1'b0, 1'b1);
        idle_bits(3);
        chk("par_bad_done", 32'(done_cnt - d0), 32'd1);
        chk("par_bad_perr", 32'(perr_done - pd0), 32'd1);
        chk("par_bad_data", 32'(bus.rx_data), 32'h07);
        p0 = perr_cnt;
        send_frame(8'h07, 1'b0, 1'b0);
        idle_bits(3);
        chk("par_good_perr", 32'(perr_cnt - p0), 32'd0);
        chk("par_good_done", 32'(done_cnt - d0), 32'd2);
`else
        p0 = perr_cnt; pd0 = perr_done;
`endif

        chk("never_both", 32'(both_cnt), 32'd0);
        chk("pulse_width", 32'(wide_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
